// File: rtl/io_pinmux.sv
// ---------------------------------------------------------------------------
// io_pinmux
// Pad multiplexer and input conditioner for the Tiny Tapeout pads.
//
// Each pad has a run-time function select, a registered output/output-enable,
// a two-flop input synchroniser, an optional glitch filter, optional input
// inversion and registered rise/fall edge pulses.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       synchronous active-low reset
//   ena_i        tile enable; 0 parks every pad (out=0, oe=0)
//   cfg_we_i     config write strobe
//   cfg_addr_i   pin index for config write and read
//   cfg_wdata_i  {inv, filt_en, -, func_sel[FW-1:0]}
//   cfg_rdata_o  config of pin cfg_addr_i (combinational, 0 when out of range)
//   func_out_i   function output data, bit f*NUM_PINS+p
//   func_oe_i    function output enables, same packing
//   pad_in_i     raw asynchronous pad inputs
//   pad_out_o    registered pad output data
//   pad_oe_o     registered pad output enables (1 = drive)
//   pin_in_o     conditioned input seen by all functions
//   edge_rise_o  one-cycle pulse on 0->1 of pin_in_o
//   edge_fall_o  one-cycle pulse on 1->0 of pin_in_o
// ---------------------------------------------------------------------------
module io_pinmux #(
    parameter int NUM_PINS  = 8,
    parameter int NUM_FUNCS = 4,
    parameter int FILT_LEN  = 4,
    parameter int AW        = (NUM_PINS  > 1) ? $clog2(NUM_PINS)  : 1,
    parameter int FW        = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          ena_i,
    input  logic                          cfg_we_i,
    input  logic [AW-1:0]                 cfg_addr_i,
    input  logic [7:0]                    cfg_wdata_i,
    output logic [7:0]                    cfg_rdata_o,
    input  logic [NUM_FUNCS*NUM_PINS-1:0] func_out_i,
    input  logic [NUM_FUNCS*NUM_PINS-1:0] func_oe_i,
    input  logic [NUM_PINS-1:0]           pad_in_i,
    output logic [NUM_PINS-1:0]           pad_out_o,
    output logic [NUM_PINS-1:0]           pad_oe_o,
    output logic [NUM_PINS-1:0]           pin_in_o,
    output logic [NUM_PINS-1:0]           edge_rise_o,
    output logic [NUM_PINS-1:0]           edge_fall_o
);

    // Terminal count of the filter: a change is accepted on the FILT_LEN-th
    // consecutive mismatching cycle.
    localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

    logic [FW-1:0]       func_sel_reg [NUM_PINS];
    logic [NUM_PINS-1:0] filt_en_reg;
    logic [NUM_PINS-1:0] inv_reg;

    // Read-back: address decode by comparison against each pin index, so
    // out-of-range addresses simply match nothing and read 0.
    always_comb begin
        cfg_rdata_o = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (cfg_addr_i == AW'(p)) begin
                cfg_rdata_o[FW-1:0] = func_sel_reg[p];
                cfg_rdata_o[6]      = filt_en_reg[p];
                cfg_rdata_o[7]      = inv_reg[p];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic       out_reg, out_next;
            logic       oe_reg,  oe_next;
            logic       sync1_reg, sync2_reg;
            logic       st_reg,  st_next;
            logic [7:0] cnt_reg, cnt_next;
            logic       rise_reg, fall_reg;

            // Per-pin config register; writes to addresses >= NUM_PINS
            // never match any pin.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    func_sel_reg[gi] <= '0;
                    filt_en_reg[gi]  <= 1'b0;
                    inv_reg[gi]      <= 1'b0;
                end else if (cfg_we_i && (cfg_addr_i == AW'(gi))) begin
                    func_sel_reg[gi] <= cfg_wdata_i[FW-1:0];
                    filt_en_reg[gi]  <= cfg_wdata_i[6];
                    inv_reg[gi]      <= cfg_wdata_i[7];
                end
            end

            // Output mux. Function 0 and selects >= NUM_FUNCS never match,
            // leaving the pad parked. Data is gated by the enable so an
            // undriven pad always shows 0.
            always_comb begin
                out_next = 1'b0;
                oe_next  = 1'b0;
                if (ena_i) begin
                    for (int f = 1; f < NUM_FUNCS; f++) begin
                        if (func_sel_reg[gi] == FW'(f)) begin
                            oe_next  = func_oe_i[f*NUM_PINS+gi];
                            out_next = func_out_i[f*NUM_PINS+gi]
                                     & func_oe_i[f*NUM_PINS+gi];
                        end
                    end
                end
            end

            // Glitch filter / stable-value tracking.
            always_comb begin
                st_next  = st_reg;
                cnt_next = cnt_reg;
                if (!filt_en_reg[gi]) begin
                    st_next  = sync2_reg;
                    cnt_next = 8'd0;
                end else if (sync2_reg == st_reg) begin
                    cnt_next = 8'd0;
                end else if (cnt_reg == CNT_LAST) begin
                    st_next  = sync2_reg;
                    cnt_next = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    out_reg   <= 1'b0;
                    oe_reg    <= 1'b0;
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    st_reg    <= 1'b0;
                    cnt_reg   <= 8'd0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    out_reg   <= out_next;
                    oe_reg    <= oe_next;
                    // Inversion sits before the synchroniser so toggling inv
                    // looks exactly like a pad transition.
                    sync1_reg <= pad_in_i[gi] ^ inv_reg[gi];
                    sync2_reg <= sync1_reg;
                    st_reg    <= st_next;
                    cnt_reg   <= cnt_next;
                    rise_reg  <= st_next & ~st_reg;
                    fall_reg  <= ~st_next & st_reg;
                end
            end

            assign pad_out_o[gi]   = out_reg;
            assign pad_oe_o[gi]    = oe_reg;
            assign pin_in_o[gi]    = st_reg;
            assign edge_rise_o[gi] = rise_reg;
            assign edge_fall_o[gi] = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_io_pinmux.sv
// ---------------------------------------------------------------------------
// tb_io_pinmux
// Directed test of io_pinmux (8 pins, 4 functions, FILT_LEN=4, AW=4 so that
// an out-of-range address can be presented). Inputs change 1 ns after each
// rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_io_pinmux;

    localparam int NP = 8;
    localparam int NF = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          ena_i;
    logic          cfg_we_i;
    logic [3:0]    cfg_addr_i;
    logic [7:0]    cfg_wdata_i;
    logic [7:0]    cfg_rdata_o;
    logic [NF*NP-1:0] func_out_i;
    logic [NF*NP-1:0] func_oe_i;
    logic [NP-1:0] pad_in_i;
    logic [NP-1:0] pad_out_o;
    logic [NP-1:0] pad_oe_o;
    logic [NP-1:0] pin_in_o;
    logic [NP-1:0] edge_rise_o;
    logic [NP-1:0] edge_fall_o;

    int err_cnt   = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    io_pinmux #(
        .NUM_PINS (NP),
        .NUM_FUNCS(NF),
        .FILT_LEN (4),
        .AW       (4),
        .FW       (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .ena_i      (ena_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_addr_i (cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o),
        .func_out_i (func_out_i),
        .func_oe_i  (func_oe_i),
        .pad_in_i   (pad_in_i),
        .pad_out_o  (pad_out_o),
        .pad_oe_o   (pad_oe_o),
        .pin_in_o   (pin_in_o),
        .edge_rise_o(edge_rise_o),
        .edge_fall_o(edge_fall_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    task automatic cfg_read(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        cfg_addr_i = addr;
        #1;
        check(tag, 32'(cfg_rdata_o), 32'(exp));
    endtask

    initial begin
        rst_ni      = 1'b0;
        ena_i       = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_addr_i  = '0;
        cfg_wdata_i = '0;
        func_out_i  = '1;
        func_oe_i   = '1;
        pad_in_i    = 8'hFF;

        // Reset state with pads high and every function driving.
        repeat (3) tick();
        check("rst_oe",   32'(pad_oe_o),    32'h0);
        check("rst_out",  32'(pad_out_o),   32'h0);
        check("rst_pin",  32'(pin_in_o),    32'h0);
        check("rst_rise", 32'(edge_rise_o), 32'h0);
        check("rst_fall", 32'(edge_fall_o), 32'h0);

        // Release: pin_in reaches 0xFF after the third edge, with one rise pulse.
        rst_ni = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("rel_pin_%0d", i),  32'(pin_in_o),    (i >= 3) ? 32'hFF : 32'h0);
            check($sformatf("rel_rise_%0d", i), 32'(edge_rise_o), (i == 3) ? 32'hFF : 32'h0);
        end
        check("rel_oe", 32'(pad_oe_o), 32'h0);

        // Pads fall: fall pulse on all pins.
        pad_in_i = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("dn_pin_%0d", i),  32'(pin_in_o),    (i >= 3) ? 32'h0 : 32'hFF);
            check($sformatf("dn_fall_%0d", i), 32'(edge_fall_o), (i == 3) ? 32'hFF : 32'h0);
        end

        // Function 2 on pin 3.
        func_out_i     = '0;
        func_oe_i      = '0;
        func_out_i[19] = 1'b1;
        func_oe_i[19]  = 1'b1;
        func_out_i[11] = 1'b1;            // function 1 on pin 3, not selected
        func_oe_i[11]  = 1'b1;
        cfg_write(4'd3, 8'h02);
        check("sel_oe_lat",  32'(pad_oe_o), 32'h0);
        cfg_read("rd_pin3", 4'd3, 8'h02);
        tick();
        check("sel_oe",  32'(pad_oe_o),  32'h08);
        check("sel_out", 32'(pad_out_o), 32'h08);
        func_oe_i[19] = 1'b0;
        tick();
        check("gate_oe",  32'(pad_oe_o),  32'h0);
        check("gate_out", 32'(pad_out_o), 32'h0);
        func_oe_i[19] = 1'b1;
        func_out_i[19] = 1'b0;
        tick();
        check("lo_oe",  32'(pad_oe_o),  32'h08);
        check("lo_out", 32'(pad_out_o), 32'h0);
        func_out_i[19] = 1'b1;
        ena_i = 1'b0;
        tick();
        check("ena0_oe",  32'(pad_oe_o),  32'h0);
        check("ena0_out", 32'(pad_out_o), 32'h0);
        ena_i = 1'b1;
        tick();
        check("ena1_out", 32'(pad_out_o), 32'h08);
        cfg_write(4'd3, 8'h00);
        check("sel0_lat", 32'(pad_out_o), 32'h08);
        tick();
        check("sel0_oe",  32'(pad_oe_o),  32'h0);
        check("sel0_out", 32'(pad_out_o), 32'h0);

        // Glitch filter on pin 0: 3-cycle glitch rejected.
        cfg_write(4'd0, 8'h40);
        tick();
        pad_in_i[0] = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick();
            check($sformatf("gl_pin_%0d", i),  32'(pin_in_o),    32'h0);
            check($sformatf("gl_rise_%0d", i), 32'(edge_rise_o), 32'h0);
            if (i == 2) pad_in_i[0] = 1'b0;
        end

        // 4-cycle pulse accepted, 5 edges after the first high sample.
        pad_in_i[0] = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            tick();
            check($sformatf("f4_pin_%0d", i),  32'(pin_in_o),    (i >= 5 && i <= 8) ? 32'h1 : 32'h0);
            check($sformatf("f4_rise_%0d", i), 32'(edge_rise_o), (i == 5) ? 32'h1 : 32'h0);
            check($sformatf("f4_fall_%0d", i), 32'(edge_fall_o), (i == 9) ? 32'h1 : 32'h0);
            if (i == 3) pad_in_i[0] = 1'b0;
        end

        // Inversion on pin 5 while the pad is low.
        cfg_write(4'd5, 8'h80);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("inv_pin_%0d", i),  32'(pin_in_o),    (i >= 3) ? 32'h20 : 32'h0);
            check($sformatf("inv_rise_%0d", i), 32'(edge_rise_o), (i == 3) ? 32'h20 : 32'h0);
        end
        cfg_read("rd_pin5", 4'd5, 8'h80);

        // Out-of-range write is ignored.
        cfg_write(4'd9, 8'hFF);
        cfg_read("rd_addr9", 4'd9, 8'h00);
        cfg_read("rd_pin1",  4'd1, 8'h00);
        cfg_read("rd_pin0",  4'd0, 8'h40);
        cfg_read("rd_pin5b", 4'd5, 8'h80);
        cfg_read("rd_pin3b", 4'd3, 8'h00);

        // Reset in the middle of a filter count.
        pad_in_i[0] = 1'b1;
        for (int i = 0; i <= 3; i++) tick();
        check("mid_pin", 32'(pin_in_o), 32'h20);
        rst_ni = 1'b0;
        tick();
        check("mrst_pin",  32'(pin_in_o),    32'h0);
        check("mrst_rise", 32'(edge_rise_o), 32'h0);
        check("mrst_fall", 32'(edge_fall_o), 32'h0);
        cfg_read("mrst_cfg5", 4'd5, 8'h00);
        rst_ni = 1'b1;
        cfg_write(4'd0, 8'h40);
        check("post_rise", 32'(edge_rise_o), 32'h0);
        check("post_fall", 32'(edge_fall_o), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("rf_pin_%0d", i),  32'(pin_in_o),    (i >= 5) ? 32'h1 : 32'h0);
            check($sformatf("rf_rise_%0d", i), 32'(edge_rise_o), (i == 5) ? 32'h1 : 32'h0);
            check($sformatf("rf_fall_%0d", i), 32'(edge_fall_o), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
